// File: rtl/cpu_pkg.sv
// Shared control-unit constants: control-word bit positions, multiplier FSM encoding, datapath width.
// No logic; pure declarations.
// Imported by the multiplier and the ACC/MR register logic.
package cpu_pkg;

  // Control-word bit indices
  localparam int MR_CLEAR   = 21;
  localparam int MUL_START  = 22;
  localparam int MUL_SIGNED = 23;

  // Datapath width of ACC / MR
  localparam int DATA_W = 16;

  // Multiplier FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } mul_state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential 16x16 radix-2 shift-add multiplier; signed via magnitudes plus final negate.
// Latency 17 cycles start-to-done; one-cycle done/acc_we/mr_we pulse.
// No backpressure: start is ignored while busy, nothing is queued.
module mul_seq
  import cpu_pkg::*;
#(
  parameter int START_BIT  = MUL_START,
  parameter int SIGNED_BIT = MUL_SIGNED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       control_signal,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic              acc_we,
  output logic              mr_we,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] mr_out,
  output logic              ovf
);

  mul_state_e            r_state;
  logic [DATA_W-1:0]     r_mcand;
  logic [DATA_W-1:0]     r_mplr;
  logic [2*DATA_W-1:0]   r_prod;
  logic [4:0]            r_cnt;
  logic                  r_neg;
  logic                  r_signed;

  logic                  w_start;
  logic                  w_sgn;
  logic [DATA_W-1:0]     w_a_mag;
  logic [DATA_W-1:0]     w_b_mag;
  logic [DATA_W:0]       w_sum;
  logic [2*DATA_W-1:0]   w_res;
  logic                  w_ovf;
  logic                  w_unused_ctrl;

  assign w_start = control_signal[START_BIT];
  assign w_sgn   = control_signal[SIGNED_BIT];

  // Only the two multiplier bits of the control word matter here
  assign w_unused_ctrl = ^control_signal;

  // Magnitudes: -(0x8000) wraps back to 0x8000, which is the correct unsigned magnitude
  assign w_a_mag = (w_sgn && a_in[DATA_W-1]) ? (~a_in + 1'b1) : a_in;
  assign w_b_mag = (w_sgn && b_in[DATA_W-1]) ? (~b_in + 1'b1) : b_in;

  // Add multiplicand into the upper half with carry-out; the carry becomes bit 31 after the shift
  assign w_sum = {1'b0, r_prod[2*DATA_W-1:DATA_W]} +
                 {1'b0, (r_mplr[0] ? r_mcand : {DATA_W{1'b0}})};

  // Sign fix-up and overflow test on the final product
  assign w_res = r_neg ? (~r_prod + 1'b1) : r_prod;
  assign w_ovf = r_signed ? (w_res[2*DATA_W-1:DATA_W] != {DATA_W{w_res[DATA_W-1]}})
                          : (w_res[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});

  // Control FSM, shift-add datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_we   <= 1'b0;
      mr_we    <= 1'b0;
      acc_out  <= '0;
      mr_out   <= '0;
      ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mcand  <= w_a_mag;
            r_mplr   <= w_b_mag;
            r_signed <= w_sgn;
            r_neg    <= w_sgn & (a_in[DATA_W-1] ^ b_in[DATA_W-1]);
            r_prod   <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_prod <= {w_sum, r_prod[DATA_W-1:1]};
          r_mplr <= r_mplr >> 1;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd15) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          acc_out <= w_res[2*DATA_W-1:DATA_W];
          mr_out  <= w_res[DATA_W-1:0];
          ovf     <= w_ovf;
          done    <= 1'b1;
          acc_we  <= 1'b1;
          mr_we   <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          acc_we  <= 1'b0;
          mr_we   <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Randomised and directed checks of mul_seq against an arithmetic reference product.
module tb_mul_seq;

  localparam int SB = 22;
  localparam int GB = 23;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] control_signal;
  logic [15:0] a_in, b_in;
  logic        busy, done, acc_we, mr_we, ovf;
  logic [15:0] acc_out, mr_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_seq dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .a_in           (a_in),
    .b_in           (b_in),
    .busy           (busy),
    .done           (done),
    .acc_we         (acc_we),
    .mr_we          (mr_we),
    .acc_out        (acc_out),
    .mr_out         (mr_out),
    .ovf            (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, product} from plain integer arithmetic
  function automatic logic [32:0] ref_mul(input bit sg, input logic [15:0] a, input logic [15:0] b);
    longint p;
    logic [31:0] w;
    logic o;
    if (sg) begin
      p = longint'($signed(a)) * longint'($signed(b));
      o = (p < -32768) || (p > 32767);
    end else begin
      p = longint'(a) * longint'(b);
      o = (p > 65535);
    end
    w = p[31:0];
    return {o, w};
  endfunction

  // Present start for one edge (edge k), then scramble operands; returns #1 after edge k
  task automatic launch(input bit sg, input logic [15:0] a, input logic [15:0] b);
    control_signal     = 32'h0;
    control_signal[SB] = 1'b1;
    control_signal[GB] = sg;
    a_in = a;
    b_in = b;
    @(posedge clk); #1;
    control_signal = 32'h0;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
  endtask

  task automatic run_op(input bit sg, input logic [15:0] a, input logic [15:0] b,
                        input int repulse, input string tag);
    logic [32:0] e;
    int c;
    e = ref_mul(sg, a, b);
    launch(sg, a, b);
    chk($sformatf("%s.busy0", tag), 32'(busy), 32'd1);
    c = 0;
    while (!done && c < 40) begin
      if (repulse != 0 && c + 1 == repulse) begin
        control_signal[SB] = 1'b1;
        a_in = 16'h1234;
        b_in = 16'h0002;
      end else begin
        control_signal = 32'h0;
      end
      @(posedge clk); #1;
      c++;
    end
    control_signal = 32'h0;
    chk($sformatf("%s.lat", tag), 32'(c), 32'd17);
    chk($sformatf("%s.acc", tag), 32'(acc_out), 32'(e[31:16]));
    chk($sformatf("%s.mr", tag), 32'(mr_out), 32'(e[15:0]));
    chk($sformatf("%s.ovf", tag), 32'(ovf), 32'(e[32]));
    chk($sformatf("%s.we", tag), {30'd0, acc_we, mr_we}, 32'd3);
    chk($sformatf("%s.busyd", tag), 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk($sformatf("%s.pulse", tag), {30'd0, done, busy}, 32'd0);
    chk($sformatf("%s.hold", tag), {acc_out, mr_out}, e[31:0]);
  endtask

  logic [15:0] corners [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

  initial begin : main
    int done_cnt;
    int done_at [2];
    logic [15:0] done_val [2];
    int low_cnt;
    int low_at;
    bit sg;
    logic [15:0] ra, rb;

    rst = 1'b1;
    control_signal = 32'h0;
    a_in = 16'h0;
    b_in = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.flags", {27'd0, busy, done, acc_we, mr_we, ovf}, 32'd0);
    chk("rst.data", {acc_out, mr_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(1'b0, 16'h0003, 16'h0005, 0, "u3x5");
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, "uFFxFF");
    run_op(1'b1, 16'hFFFD, 16'h0007, 0, "s-3x7");
    run_op(1'b1, 16'h8000, 16'h8000, 0, "s8000sq");
    run_op(1'b1, 16'h8000, 16'h0001, 0, "s8000x1");

    // Reset mid-CALC from a state with nonzero held outputs
    launch(1'b0, 16'h00FF, 16'h0101);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.flags", {27'd0, busy, done, acc_we, mr_we, ovf}, 32'd0);
    chk("abort.data", {acc_out, mr_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort.nodone", 32'(done_cnt), 32'd0);

    // Restart pulse in CALC must be ignored
    run_op(1'b0, 16'h0003, 16'h0005, 5, "repulse");

    // Start held high: back-to-back at the minimum interval
    control_signal     = 32'h0;
    control_signal[SB] = 1'b1;
    a_in = 16'd2;
    b_in = 16'd3;
    @(posedge clk); #1;
    a_in = 16'd4;
    b_in = 16'd5;
    done_cnt = 0;
    low_cnt  = 0;
    low_at   = -1;
    done_at  = '{-1, -1};
    done_val = '{16'h0, 16'h0};
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (done_cnt < 2) begin
          done_at[done_cnt]  = c;
          done_val[done_cnt] = mr_out;
        end
        done_cnt++;
      end
      if (!busy && c <= 36) begin
        low_cnt++;
        low_at = c;
      end
      if (c == 36) control_signal = 32'h0;
    end
    chk("held.ndone", 32'(done_cnt), 32'd2);
    chk("held.t1", 32'(done_at[0]), 32'd17);
    chk("held.v1", 32'(done_val[0]), 32'h0006);
    chk("held.t2", 32'(done_at[1]), 32'd36);
    chk("held.v2", 32'(done_val[1]), 32'h0014);
    chk("held.nlow", 32'(low_cnt), 32'd1);
    chk("held.lowat", 32'(low_at), 32'd18);

    // Randomised operands with corner values mixed in
    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      run_op(sg, ra, rb, 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
